// File: rtl/ctrl_pipe_if.sv
// ID-to-EX control bus for ctrl_pipe: decoded-instruction fields in, registered control bundle out.
// The slave modport is the pipeline register; the master modport is the decode/EX side that drives and observes it.
interface ctrl_pipe_if;
  logic       i_valid;
  logic [6:0] i_opcode;
  logic [2:0] i_funct3;
  logic [6:0] i_funct7;
  logic [5:0] i_format;
  logic [4:0] i_rs1;
  logic [4:0] i_rs2;
  logic [4:0] i_rd;
  logic       i_flush;

  logic       o_stall;
  logic       o_md_busy;
  logic       o_ex_valid;
  logic [2:0] o_ex_alu_op;
  logic [3:0] o_ex_branch_op;
  logic       o_ex_mem_write;
  logic       o_ex_mem_read;
  logic       o_ex_reg_write;
  logic [1:0] o_ex_wb_sel;
  logic       o_ex_alu_src;
  logic       o_ex_pc_src;
  logic [3:0] o_ex_dmem_mask;
  logic       o_ex_sub;
  logic       o_ex_unsigned;
  logic       o_ex_arith;
  logic       o_ex_jalr;
  logic       o_ex_alu_pc;
  logic       o_ex_lui;
  logic       o_ex_md;
  logic       o_ex_illegal;
  logic [4:0] o_ex_rd;
  logic [4:0] o_ex_rs1;
  logic [4:0] o_ex_rs2;

  modport slave (
    input  i_valid, i_opcode, i_funct3, i_funct7, i_format, i_rs1, i_rs2, i_rd, i_flush,
    output o_stall, o_md_busy, o_ex_valid, o_ex_alu_op, o_ex_branch_op, o_ex_mem_write,
           o_ex_mem_read, o_ex_reg_write, o_ex_wb_sel, o_ex_alu_src, o_ex_pc_src,
           o_ex_dmem_mask, o_ex_sub, o_ex_unsigned, o_ex_arith, o_ex_jalr, o_ex_alu_pc,
           o_ex_lui, o_ex_md, o_ex_illegal, o_ex_rd, o_ex_rs1, o_ex_rs2
  );

  modport master (
    output i_valid, i_opcode, i_funct3, i_funct7, i_format, i_rs1, i_rs2, i_rd, i_flush,
    input  o_stall, o_md_busy, o_ex_valid, o_ex_alu_op, o_ex_branch_op, o_ex_mem_write,
           o_ex_mem_read, o_ex_reg_write, o_ex_wb_sel, o_ex_alu_src, o_ex_pc_src,
           o_ex_dmem_mask, o_ex_sub, o_ex_unsigned, o_ex_arith, o_ex_jalr, o_ex_alu_pc,
           o_ex_lui, o_ex_md, o_ex_illegal, o_ex_rd, o_ex_rs1, o_ex_rs2
  );
endinterface

// File: rtl/ctrl_pipe.sv
// RV32I control decoder with an ID/EX pipeline register, load-use bubble insertion,
// branch/jump flush and multi-cycle M-extension sequencing.
module ctrl_pipe #(
  parameter int ENABLE_M   = 1,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input logic        i_clk,
  input logic        i_rst,
  ctrl_pipe_if.slave bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [6:0] F7_MD    = 7'b0000001;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef struct packed {
    logic       valid;
    logic [2:0] alu_op;
    logic [3:0] branch_op;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src;
    logic       pc_src;
    logic [3:0] dmem_mask;
    logic       sub;
    logic       uns;
    logic       arith;
    logic       jalr;
    logic       alu_pc;
    logic       lui;
    logic       md;
    logic       illegal;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } bundle_t;

  bundle_t         ex_q, ex_d, dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;
  logic is_jalr, is_load, md_pat, one_hot, rs1_used, rs2_used, load_use;

  assign fmt_r    = bus.i_format[0];
  assign fmt_i    = bus.i_format[1];
  assign fmt_s    = bus.i_format[2];
  assign fmt_b    = bus.i_format[3];
  assign fmt_u    = bus.i_format[4];
  assign fmt_j    = bus.i_format[5];
  assign is_jalr  = (bus.i_opcode == OP_JALR);
  assign is_load  = (bus.i_opcode == OP_LOAD);
  assign md_pat   = (bus.i_opcode == OP_REG) && (bus.i_funct7 == F7_MD);
  assign one_hot  = (bus.i_format != 6'd0) && ((bus.i_format & (bus.i_format - 6'd1)) == 6'd0);
  assign rs1_used = fmt_r | fmt_i | fmt_s | fmt_b;
  assign rs2_used = fmt_r | fmt_s | fmt_b;

  // An empty ID slot decodes to the all-zero bundle so EX sees a clean bubble.
  always_comb begin
    dec = '0;
    if (bus.i_valid) begin
      dec.valid     = 1'b1;
      dec.alu_op    = (fmt_r | fmt_i) ? bus.i_funct3 : 3'b000;
      dec.branch_op = {fmt_j | is_jalr, fmt_b ? bus.i_funct3 : 3'b000};
      dec.mem_write = fmt_s;
      dec.mem_read  = is_load;
      dec.reg_write = fmt_r | fmt_i | fmt_u | fmt_j;
      dec.wb_sel    = (fmt_j | is_jalr) ? 2'b01 : (is_load ? 2'b10 : 2'b00);
      dec.alu_src   = !(fmt_r | fmt_b);
      dec.pc_src    = fmt_b | fmt_j | is_jalr;
      if (fmt_s | is_load) begin
        case (bus.i_funct3[1:0])
          2'b00:   dec.dmem_mask = 4'b0001;
          2'b01:   dec.dmem_mask = 4'b0011;
          default: dec.dmem_mask = 4'b1111;
        endcase
      end
      dec.md      = (ENABLE_M != 0) && md_pat;
      dec.sub     = fmt_r && (bus.i_funct7 == F7_ALT) && !dec.md;
      dec.uns     = (((fmt_r | fmt_i) && (bus.i_funct3 == 3'b011)) || (fmt_b && bus.i_funct3[1]))
                    && !dec.md;
      dec.arith   = (fmt_r | fmt_i) && (bus.i_funct3 == 3'b101) && (bus.i_funct7 == F7_ALT)
                    && !dec.md;
      dec.jalr    = is_jalr;
      dec.alu_pc  = (bus.i_opcode == OP_AUIPC);
      dec.lui     = (bus.i_opcode == OP_LUI);
      dec.illegal = !one_hot || (md_pat && (ENABLE_M == 0));
      dec.rd      = bus.i_rd;
      dec.rs1     = bus.i_rs1;
      dec.rs2     = bus.i_rs2;
    end
  end

  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && bus.i_valid &&
                    ((rs1_used && (bus.i_rs1 == ex_q.rd)) || (rs2_used && (bus.i_rs2 == ex_q.rd)));

  // Priority: flush, then multi-cycle hold, then load-use bubble, then normal capture.
  always_comb begin
    ex_d        = dec;
    cnt_d       = '0;
    bus.o_stall = 1'b0;
    if (bus.i_flush) begin
      ex_d = '0;
    end else if (cnt_q != '0) begin
      ex_d        = ex_q;
      cnt_d       = cnt_q - CNT_W'(1);
      bus.o_stall = 1'b1;
    end else if (load_use) begin
      ex_d        = '0;
      bus.o_stall = 1'b1;
    end else if (dec.md) begin
      cnt_d = bus.i_funct3[2] ? DIV_LOAD : MUL_LOAD;
    end
    if (i_rst) bus.o_stall = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.o_md_busy      = (cnt_q != '0);
  assign bus.o_ex_valid     = ex_q.valid;
  assign bus.o_ex_alu_op    = ex_q.alu_op;
  assign bus.o_ex_branch_op = ex_q.branch_op;
  assign bus.o_ex_mem_write = ex_q.mem_write;
  assign bus.o_ex_mem_read  = ex_q.mem_read;
  assign bus.o_ex_reg_write = ex_q.reg_write;
  assign bus.o_ex_wb_sel    = ex_q.wb_sel;
  assign bus.o_ex_alu_src   = ex_q.alu_src;
  assign bus.o_ex_pc_src    = ex_q.pc_src;
  assign bus.o_ex_dmem_mask = ex_q.dmem_mask;
  assign bus.o_ex_sub       = ex_q.sub;
  assign bus.o_ex_unsigned  = ex_q.uns;
  assign bus.o_ex_arith     = ex_q.arith;
  assign bus.o_ex_jalr      = ex_q.jalr;
  assign bus.o_ex_alu_pc    = ex_q.alu_pc;
  assign bus.o_ex_lui       = ex_q.lui;
  assign bus.o_ex_md        = ex_q.md;
  assign bus.o_ex_illegal   = ex_q.illegal;
  assign bus.o_ex_rd        = ex_q.rd;
  assign bus.o_ex_rs1       = ex_q.rs1;
  assign bus.o_ex_rs2       = ex_q.rs2;

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Registered successor to the combinational RV32I control decoder.
- Decodes the ID-stage instruction fields into the full control bundle and captures it in an ID/EX pipeline register with a valid bit.
- Detects load-use hazards and inserts a bubble when one occurs.
- Optionally sequences multi-cycle M-extension ops, holding EX and stalling upstream for a parametrised number of cycles.
- Accepts branch/jump flushes.
- Sits between the decode module and the EX stage.

Parameters:
ENABLE_M, 1, 1 = decode M-extension ops (opcode 0110011, funct7 0000001); 0 = flag them as illegal.
MUL_CYCLES, 1, EX residency of MUL/MULH/MULHSU/MULHU (funct3[2]=0); must be >=1.
DIV_CYCLES, 33, EX residency of DIV/DIVU/REM/REMU (funct3[2]=1); must be >=1.
CNT_W, 6, cycle counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_valid  in  1  ID holds a valid instruction
i_opcode  in  7  instruction opcode
i_funct3  in  3  instruction funct3
i_funct7  in  7  instruction funct7
i_format  in  6  one-hot format: R=000001, I=000010, S=000100, B=001000, U=010000, J=100000
i_rs1, i_rs2, i_rd  in  5 each  register indices
i_flush  in  1  redirect taken; kill ID/EX contents
o_stall  out  1  hold PC and IF/ID this cycle (combinational)
o_md_busy  out  1  multi-cycle op occupying EX (combinational from counter)
o_ex_valid  out  1  ID/EX entry valid
o_ex_alu_op  out  3  ALU op
o_ex_branch_op  out  4  branch op
o_ex_mem_write  out  1  store
o_ex_mem_read  out  1  load
o_ex_reg_write  out  1  register write enable
o_ex_wb_sel  out  2  write-back source select
o_ex_alu_src  out  1  ALU operand-2 source
o_ex_pc_src  out  1  PC source
o_ex_dmem_mask  out  4  data-memory byte mask
o_ex_sub  out  1  ALU subtract
o_ex_unsigned  out  1  unsigned compare
o_ex_arith  out  1  arithmetic shift
o_ex_jalr  out  1  JALR
o_ex_alu_pc  out  1  ALU operand-1 = PC
o_ex_lui  out  1  LUI
o_ex_md  out  1  M-extension op
o_ex_illegal  out  1  illegal instruction
o_ex_rd  out  5  destination register
o_ex_rs1, o_ex_rs2  out  5 each  source registers

Behaviour:
Decode (combinational, on ID fields; JALR = opcode 1100111):
- alu_op: funct3 if R or I, else 000.
- branch_op: {J|JALR, B ? funct3 : 000}.
- mem_write: S.
- reg_write: R|I|U|J.
- wb_sel: 01 if J|JALR; else 10 if opcode 0000011; else 00.
- alu_src: 0 for R or B, 1 otherwise.
- pc_src: B|J|JALR.
- dmem_mask (S or load only, else 0000): funct3[1:0] 00->0001, 01->0011, otherwise 1111.
- sub: R & funct7=0100000.
- unsigned: ((R|I) & funct3=011) | (B & funct3[1]).
- arith: (R|I) & funct3=101 & funct7=0100000.
- jalr: JALR.
- alu_pc: opcode 0010111.
- mem_read: opcode 0000011.
- lui: opcode 0110111.
- md: ENABLE_M & opcode 0110011 & funct7 0000001; when md=1, force sub=0, arith=0, unsigned=0.
- illegal: i_valid & (i_format not one-hot, or (md-pattern & !ENABLE_M)).
- Source usage: rs1 used for R/I/S/B; rs2 used for R/S/B.

Pipeline register, 1-cycle latency; priority per cycle:
1. i_rst: clear all o_ex_* to 0, counter = 0.
2. i_flush: bundle cleared to 0 (o_ex_valid=0), counter = 0; o_stall=0 that cycle.
3. md hold (counter != 0): EX register unchanged, counter decrements, o_stall=1.
4. load-use: o_ex_valid & o_ex_mem_read & o_ex_rd!=0 & i_valid & ((rs1 used & i_rs1==o_ex_rd) | (rs2 used & i_rs2==o_ex_rd)). Result: bubble loaded (bundle all 0), o_stall=1.
5. Normal: capture decoded bundle with o_ex_valid=i_valid. If captured md & i_valid: counter = (funct3[2] ? DIV_CYCLES : MUL_CYCLES) - 1.

Timing and boundary rules:
- o_md_busy = (counter != 0); counter saturates at 0.
- With CYCLES=1 there is no stall, so an M op behaves like an ALU op.
- An invalid slot (i_valid=0) always captures an all-zero bundle.
- Flush during md hold aborts the op immediately.
- Reset mid-hold has the same effect.
- Load-use is never evaluated while counter != 0 (EX holds a non-load).

Test Plan:
- Reset: hold i_rst 2 cycles with i_valid=1 ADD -> all o_ex_*=0, o_stall=0 during reset; first ADD valid one cycle after release.
- SRAI (I, funct3 101, funct7 0100000) -> next cycle o_ex_alu_op=101, o_ex_arith=1, o_ex_alu_src=1, o_ex_reg_write=1; LH -> dmem_mask=0011, wb_sel=10, mem_read=1.
- LW x5 then ADD x6,x5,x1 -> one cycle o_stall=1 with o_ex_valid=0 bubble, then ADD valid; repeat with rd=x0 -> no stall.
- DIV, DIV_CYCLES=33 -> o_ex_valid=1 & o_ex_md=1 held 33 cycles, o_stall=1 for 32 cycles, next instruction enters EX on cycle 34; MUL, MUL_CYCLES=1 -> no stall.
- i_flush on cycle 5 of DIV hold -> next cycle o_ex_valid=0, o_md_busy=0, o_stall=0.
- ENABLE_M=0 with MUL encoding -> o_ex_illegal=1, o_ex_md=0, no stall; i_format=000011 -> o_ex_illegal=1.
